interrupt_claim_arbiter: RTL and testbench

- Sits directly downstream of the interrupt mask stage and consumes its masked request vector.
- Latches requests into per-source pending bits and tracks which sources are in service.
- Selects the highest-priority pending source against a threshold, drives a single interrupt line to the core, and runs the claim/complete handshake that retires each interrupt.

---
 rtl/interrupt_claim_arbiter.sv | 90 +++++++++
 tb/tb_interrupt_claim_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_claim_arbiter.sv
// rtl/interrupt_claim_arbiter.sv - pending/in-service tracking, priority arbitration and claim/complete handshake
module interrupt_claim_arbiter #(
    parameter int N_interrupts = 32,
    parameter int PRIO_W = 3,
    localparam int ID_W = $clog2(N_interrupts + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_interrupts-1:0]    interrupt_requests_masked,
    input  logic [N_interrupts*PRIO_W-1:0] interrupt_priorities,
    input  logic [PRIO_W-1:0]          priority_threshold,
    input  logic                       claim_req,
    input  logic                       complete_req,
    input  logic [ID_W-1:0]            complete_id,
    output logic                       interrupt_out,
    output logic                       claim_ack,
    output logic [ID_W-1:0]            claim_id,
    output logic [N_interrupts-1:0]    pending,
    output logic [N_interrupts-1:0]    in_service
);

    logic [N_interrupts-1:0] pending_q;
    logic [N_interrupts-1:0] in_service_q;
    logic [N_interrupts-1:0] pending_d;
    logic [N_interrupts-1:0] in_service_d;
    logic [N_interrupts-1:0] set_vec;
    logic [N_interrupts-1:0] claim_vec;
    logic [N_interrupts-1:0] complete_vec;
    logic [ID_W-1:0]         best_id_q;
    logic [ID_W-1:0]         best_id_d;
    logic [PRIO_W-1:0]       best_prio_q;
    logic [PRIO_W-1:0]       best_prio_d;
    logic                    claim_hit;

    assign pending    = pending_q;
    assign in_service = in_service_q;

    // A claim only retires a source when the line is raised and a winner exists.
    assign claim_hit = claim_req && interrupt_out && (best_id_q != '0);

    // Gateway, claim and completion effects on the per-source state vectors.
    // Matching complete_id against each source ID rejects 0 and out-of-range IDs for free.
    always_comb begin
        set_vec      = '0;
        claim_vec    = '0;
        complete_vec = '0;
        for (int i = 0; i < N_interrupts; i++) begin
            set_vec[i]      = interrupt_requests_masked[i] && !pending_q[i] && !in_service_q[i];
            claim_vec[i]    = claim_hit && (best_id_q == ID_W'(i + 1));
            complete_vec[i] = complete_req && (complete_id == ID_W'(i + 1)) && in_service_q[i];
        end
        pending_d    = (pending_q | set_vec) & ~claim_vec;
        in_service_d = (in_service_q | claim_vec) & ~complete_vec;
    end

    // Arbitrate over the next-state pending vector so a just-claimed source can
    // never win again; strict compare keeps ties on the lowest index and skips priority 0.
    always_comb begin
        best_id_d   = '0;
        best_prio_d = '0;
        for (int i = 0; i < N_interrupts; i++) begin
            if (pending_d[i] && (interrupt_priorities[i*PRIO_W +: PRIO_W] > best_prio_d)) begin
                best_prio_d = interrupt_priorities[i*PRIO_W +: PRIO_W];
                best_id_d   = ID_W'(i + 1);
            end
        end
    end

    // State registers, arbitration result, interrupt line and claim response.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q     <= '0;
            in_service_q  <= '0;
            best_id_q     <= '0;
            best_prio_q   <= '0;
            interrupt_out <= 1'b0;
            claim_ack     <= 1'b0;
            claim_id      <= '0;
        end else begin
            pending_q     <= pending_d;
            in_service_q  <= in_service_d;
            best_id_q     <= best_id_d;
            best_prio_q   <= best_prio_d;
            interrupt_out <= (best_prio_q > priority_threshold);
            claim_ack     <= claim_req;
            claim_id      <= claim_hit ? best_id_q : '0;
        end
    end

endmodule

// File: tb/tb_interrupt_claim_arbiter.sv
// tb/tb_interrupt_claim_arbiter.sv - self-checking bench for interrupt_claim_arbiter
module tb_interrupt_claim_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] req;
    logic [95:0] prios;
    logic [2:0]  thr;
    logic        claim;
    logic        complete;
    logic [5:0]  cid;
    logic        intr;
    logic        ack;
    logic [5:0]  claim_id_o;
    logic [31:0] pend;
    logic [31:0] insvc;

    int checks = 0;
    int failures = 0;

    // reference state, kept as plain arrays and integers
    bit m_pend[32];
    bit m_isv[32];
    int m_bid;
    int m_bprio;
    bit m_int;
    bit m_ack;
    int m_cid;

    always #5 clk = ~clk;

    interrupt_claim_arbiter dut (
        .clk(clk),
        .rst(rst),
        .interrupt_requests_masked(req),
        .interrupt_priorities(prios),
        .priority_threshold(thr),
        .claim_req(claim),
        .complete_req(complete),
        .complete_id(cid),
        .interrupt_out(intr),
        .claim_ack(ack),
        .claim_id(claim_id_o),
        .pending(pend),
        .in_service(insvc)
    );

    function automatic int prio_of(int i);
        return int'(prios[i*3 +: 3]);
    endfunction

    // highest priority first, then lowest index
    function automatic int winner(bit p[32]);
        for (int lvl = 7; lvl >= 1; lvl--)
            for (int i = 0; i < 32; i++)
                if (p[i] && prio_of(i) == lvl) return i + 1;
        return 0;
    endfunction

    task automatic model_step();
        bit np[32];
        bit ni[32];
        int got;
        int c;
        if (rst) begin
            foreach (m_pend[i]) begin m_pend[i] = 0; m_isv[i] = 0; end
            m_bid = 0; m_bprio = 0; m_int = 0; m_ack = 0; m_cid = 0;
            return;
        end
        np = m_pend;
        ni = m_isv;
        got = 0;
        if (claim && m_int) got = m_bid;
        for (int i = 0; i < 32; i++)
            if (req[i] && !m_pend[i] && !m_isv[i]) np[i] = 1;
        if (got != 0) begin
            np[got-1] = 0;
            ni[got-1] = 1;
        end
        c = int'(cid);
        if (complete && c >= 1 && c <= 32 && m_isv[c-1]) ni[c-1] = 0;
        m_int   = (m_bprio > int'(thr));
        m_ack   = claim;
        m_cid   = got;
        m_pend  = np;
        m_isv   = ni;
        m_bid   = winner(np);
        m_bprio = (m_bid != 0) ? prio_of(m_bid - 1) : 0;
    endtask

    function automatic logic [71:0] model_vec();
        logic [31:0] p;
        logic [31:0] s;
        for (int i = 0; i < 32; i++) begin
            p[i] = m_pend[i];
            s[i] = m_isv[i];
        end
        return {p, s, m_int, m_ack, 6'(m_cid)};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_prio(int i, int p);
        prios[i*3 +: 3] = 3'(p);
    endtask

    task automatic go_reset();
        rst = 1'b1; req = '0; prios = '0; thr = '0;
        claim = 1'b0; complete = 1'b0; cid = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        go_reset();
        checks++;
        if ({pend, insvc, intr, ack, claim_id_o} !== 72'd0) begin
            failures++;
            $display("FAIL reset_state: got %h expected 0", {pend, insvc, intr, ack, claim_id_o});
        end
    endtask

    task automatic test_single();
        go_reset();
        set_prio(5, 3); req[5] = 1'b1;
        tick();
        checks++;
        if (pend[5] !== 1'b1 || intr !== 1'b0) begin
            failures++; $display("FAIL single_pend: pend5=%b intr=%b expected 1 0", pend[5], intr);
        end
        tick();
        checks++;
        if (intr !== 1'b1) begin
            failures++; $display("FAIL single_intr: got %b expected 1", intr);
        end
        claim = 1'b1; tick(); claim = 1'b0;
        checks++;
        if (ack !== 1'b1 || claim_id_o !== 6'd6 || pend[5] !== 1'b0 || insvc[5] !== 1'b1) begin
            failures++;
            $display("FAIL single_claim: ack=%b id=%0d pend5=%b isv5=%b expected 1 6 0 1", ack, claim_id_o, pend[5], insvc[5]);
        end
        tick();
        checks++;
        if (ack !== 1'b0 || claim_id_o !== 6'd0) begin
            failures++; $display("FAIL single_ack_drop: ack=%b id=%0d expected 0 0", ack, claim_id_o);
        end
        tick();
        checks++;
        if (intr !== 1'b0 || model_vec() !== {pend, insvc, intr, ack, claim_id_o}) begin
            failures++;
            $display("FAIL single_end: got %h expected %h", {pend, insvc, intr, ack, claim_id_o}, model_vec());
        end
    endtask

    task automatic test_tie();
        int exp_ids[3] = '{3, 8, 10};
        go_reset();
        set_prio(2, 4); set_prio(7, 4); set_prio(9, 2);
        req = 32'h0000_0284;
        tick(); req = '0; tick();
        for (int k = 0; k < 3; k++) begin
            claim = 1'b1; tick(); claim = 1'b0;
            checks++;
            if (ack !== 1'b1 || int'(claim_id_o) != exp_ids[k]) begin
                failures++; $display("FAIL tie_claim%0d: id=%0d expected %0d", k, claim_id_o, exp_ids[k]);
            end
            tick();
        end
        checks++;
        if (insvc !== 32'h0000_0284 || pend !== 32'h0) begin
            failures++; $display("FAIL tie_state: isv=%h pend=%h expected 00000284 00000000", insvc, pend);
        end
    endtask

    task automatic test_threshold();
        go_reset();
        thr = 3'd4; set_prio(0, 4); req[0] = 1'b1;
        tick(); req = '0; tick(); tick();
        checks++;
        if (intr !== 1'b0) begin
            failures++; $display("FAIL thr_block: intr=%b expected 0", intr);
        end
        claim = 1'b1; tick(); claim = 1'b0;
        checks++;
        if (ack !== 1'b1 || claim_id_o !== 6'd0 || pend[0] !== 1'b1 || insvc !== 32'h0) begin
            failures++;
            $display("FAIL thr_claim: ack=%b id=%0d pend0=%b isv=%h expected 1 0 1 0", ack, claim_id_o, pend[0], insvc);
        end
        thr = 3'd3; tick(); tick();
        checks++;
        if (intr !== 1'b1) begin
            failures++; $display("FAIL thr_lower: intr=%b expected 1", intr);
        end
    endtask

    task automatic test_repend();
        go_reset();
        set_prio(5, 3); req[5] = 1'b1;
        tick(); tick();
        claim = 1'b1; tick(); claim = 1'b0;
        tick(); tick();
        checks++;
        if (pend[5] !== 1'b0 || insvc[5] !== 1'b1) begin
            failures++; $display("FAIL repend_hold: pend5=%b isv5=%b expected 0 1", pend[5], insvc[5]);
        end
        complete = 1'b1; cid = 6'd6; tick(); complete = 1'b0;
        checks++;
        if (pend[5] !== 1'b0 || insvc[5] !== 1'b0) begin
            failures++; $display("FAIL repend_complete: pend5=%b isv5=%b expected 0 0", pend[5], insvc[5]);
        end
        tick();
        checks++;
        if (pend[5] !== 1'b1) begin
            failures++; $display("FAIL repend_after: pend5=%b expected 1", pend[5]);
        end
    endtask

    task automatic test_bad_complete();
        int ids[3] = '{0, 33, 2};
        go_reset();
        set_prio(5, 3); req[5] = 1'b1; req[1] = 1'b1;
        tick(); req[5] = 1'b0; tick();
        claim = 1'b1; tick(); claim = 1'b0;
        for (int k = 0; k < 3; k++) begin
            complete = 1'b1; cid = 6'(ids[k]); tick(); complete = 1'b0;
            checks++;
            if (insvc !== 32'h0000_0020 || pend !== 32'h0000_0002) begin
                failures++;
                $display("FAIL bad_complete_%0d: isv=%h pend=%h expected 00000020 00000002", ids[k], insvc, pend);
            end
        end
    endtask

    task automatic test_reset_mid();
        go_reset();
        set_prio(1, 5); set_prio(4, 6); set_prio(10, 1);
        req = 32'h0000_0012;
        tick(); tick();
        claim = 1'b1; tick(); claim = 1'b0;
        checks++;
        if (claim_id_o !== 6'd5) begin
            failures++; $display("FAIL rmid_claim1: id=%0d expected 5", claim_id_o);
        end
        tick();
        claim = 1'b1; tick(); claim = 1'b0;
        checks++;
        if (claim_id_o !== 6'd2) begin
            failures++; $display("FAIL rmid_claim2: id=%0d expected 2", claim_id_o);
        end
        req[10] = 1'b1; tick();
        checks++;
        if (insvc !== 32'h0000_0012 || pend !== 32'h0000_0400) begin
            failures++; $display("FAIL rmid_pre: isv=%h pend=%h expected 00000012 00000400", insvc, pend);
        end
        rst = 1'b1; tick(); rst = 1'b0;
        checks++;
        if ({pend, insvc, intr, ack, claim_id_o} !== 72'd0) begin
            failures++; $display("FAIL rmid_reset: got %h expected 0", {pend, insvc, intr, ack, claim_id_o});
        end
        tick();
        checks++;
        if (pend !== 32'h0000_0412 || insvc !== 32'h0) begin
            failures++; $display("FAIL rmid_repend: pend=%h isv=%h expected 00000412 00000000", pend, insvc);
        end
    endtask

    task automatic test_random();
        int busy[$];
        go_reset();
        for (int i = 0; i < 32; i++) set_prio(i, $urandom_range(0, 7));
        for (int n = 0; n < 1500; n++) begin
            req      = $urandom & $urandom & $urandom;
            claim    = ($urandom_range(0, 3) == 0);
            complete = ($urandom_range(0, 2) == 0);
            busy.delete();
            for (int i = 0; i < 32; i++) if (m_isv[i]) busy.push_back(i + 1);
            if (busy.size() > 0 && $urandom_range(0, 3) != 0)
                cid = 6'(busy[$urandom_range(0, busy.size() - 1)]);
            else
                cid = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 15) == 0) thr = 3'($urandom_range(0, 4));
            if ($urandom_range(0, 31) == 0) set_prio($urandom_range(0, 31), $urandom_range(0, 7));
            rst = ($urandom_range(0, 199) == 0);
            tick();
            checks++;
            if ({pend, insvc, intr, ack, claim_id_o} !== model_vec()) begin
                failures++;
                $display("FAIL random_cycle%0d: got %h expected %h", n, {pend, insvc, intr, ack, claim_id_o}, model_vec());
            end
        end
        rst = 1'b0; claim = 1'b0; complete = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_threshold();
        test_repend();
        test_bad_complete();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
